// File: rtl/cv32e40p_if_id_voter_ft_pkg.sv
// ============================================================================
// Module  : cv32e40p_pkg
// Brief   : Shared types for the triplicated IF/ID voter: lane health
//           encoding and the 68-bit per-lane IF/ID bundle layout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_pkg;

    // Width of one lane's IF/ID bundle (valid + rdata + pc + three flags)
    localparam int IFID_BUNDLE_W = 68;

    typedef enum logic [1:0] {
        LANE_OK      = 2'd0,
        LANE_SUSPECT = 2'd1,
        LANE_FAULTY  = 2'd2
    } lane_health_e;

    // Field order fixes the packed layout: valid is the MSB
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        compressed;
        logic        illegal;
        logic        fetch_failed;
    } if_id_bundle_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_if_id_voter_ft_if.sv
// ============================================================================
// Module  : cv32e40p_if_id_voter_ft_if
// Brief   : Triplicated IF/ID bundle as driven by the fault-tolerant IF
//           stage (master) and received by the ID-side voter (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40p_if_id_voter_ft_if;
    logic [2:0]       instr_valid_id_i;
    logic [2:0][31:0] instr_rdata_id_i;
    logic [2:0]       is_compressed_id_i;
    logic [2:0]       illegal_c_insn_id_i;
    logic [2:0][31:0] pc_id_i;
    logic [2:0]       is_fetch_failed_i;

    modport master (
        output instr_valid_id_i, instr_rdata_id_i, is_compressed_id_i,
               illegal_c_insn_id_i, pc_id_i, is_fetch_failed_i
    );

    modport slave (
        input  instr_valid_id_i, instr_rdata_id_i, is_compressed_id_i,
               illegal_c_insn_id_i, pc_id_i, is_fetch_failed_i
    );
endinterface

`default_nettype wire

// File: rtl/cv32e40p_if_id_voter_ft_lane_health_fsm.sv
// ============================================================================
// Module  : cv32e40p_lane_health_fsm
// Brief   : Health tracker for one voter lane. A single run counter counts
//           either consecutive mismatches (towards FAULTY) or consecutive
//           matches (towards OK) while SUSPECT. fault_req flags that the
//           mismatch run has reached the threshold this cycle; the lane only
//           goes FAULTY if it is not needed as the last healthy lane.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_lane_health_fsm
    import cv32e40p_pkg::*;
#(
    parameter int PERM_THRESHOLD  = 4,
    parameter int CLEAR_THRESHOLD = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   evt,
    input  wire logic   mismatch,
    input  wire logic   clear,
    input  wire logic   last_healthy,
    output lane_health_e state,
    output logic        faulty,
    output logic        fault_req
);

    localparam int RUN_MAX = (PERM_THRESHOLD > CLEAR_THRESHOLD) ? PERM_THRESHOLD : CLEAR_THRESHOLD;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    lane_health_e     state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             mm_run_q, mm_run_d;   // 1: run counts mismatches, 0: matches

    // State, run counter and run type registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LANE_OK;
            run_q    <= '0;
            mm_run_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            mm_run_q <= mm_run_d;
        end
    end

    // Next-state: clear wins, otherwise only event cycles move the lane
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        mm_run_d  = mm_run_q;
        fault_req = 1'b0;
        run_inc   = (run_q == RUN_W'(RUN_MAX)) ? run_q : run_q + RUN_W'(1);
        if (clear) begin
            state_d  = LANE_OK;
            run_d    = '0;
            mm_run_d = 1'b0;
        end else if (evt) begin
            case (state_q)
                LANE_OK: begin
                    if (mismatch) begin
                        state_d  = LANE_SUSPECT;
                        run_d    = RUN_W'(1);
                        mm_run_d = 1'b1;
                    end
                end
                LANE_SUSPECT: begin
                    if (mismatch) begin
                        run_d    = mm_run_q ? run_inc : RUN_W'(1);
                        mm_run_d = 1'b1;
                        if (run_d >= RUN_W'(PERM_THRESHOLD)) begin
                            fault_req = 1'b1;
                            if (!last_healthy) begin
                                state_d = LANE_FAULTY;
                            end
                        end
                    end else begin
                        run_d    = mm_run_q ? RUN_W'(1) : run_inc;
                        mm_run_d = 1'b0;
                        if (run_d >= RUN_W'(CLEAR_THRESHOLD)) begin
                            state_d = LANE_OK;
                            run_d   = '0;
                        end
                    end
                end
                LANE_FAULTY: ;
                default: state_d = LANE_OK;
            endcase
        end
    end

    assign state  = state_q;
    assign faulty = (state_q == LANE_FAULTY);

endmodule

`default_nettype wire

// File: rtl/cv32e40p_if_id_voter_ft.sv
// ============================================================================
// Module  : cv32e40p_if_id_voter_ft
// Brief   : ID-side majority voter for the triplicated IF/ID bundle, with
//           per-lane health tracking, lane retirement and a refetch
//           request/acknowledge handshake for uncorrectable bundles.
//           Optional per-lane saturating error counters are enabled by
//           defining CV32E40P_IFID_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_if_id_voter_ft
    import cv32e40p_pkg::*;
#(
    parameter int PERM_THRESHOLD  = 4,
    parameter int CLEAR_THRESHOLD = 16,
    parameter int CNT_W           = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    cv32e40p_if_id_voter_ft_if.slave   lanes,
    input  wire logic                  health_clear_i,
    input  wire logic                  refetch_ack_i,
    output logic                       instr_valid_o,
    output logic [31:0]                instr_rdata_o,
    output logic                       is_compressed_o,
    output logic                       illegal_c_insn_o,
    output logic [31:0]                pc_o,
    output logic                       is_fetch_failed_o,
    output logic                       kill_o,
    output logic [2:0]                 lane_mismatch_o,
    output logic [2:0]                 lane_faulty_o,
    output logic                       degraded_o,
    output logic                       refetch_req_o,
    output logic [31:0]                refetch_pc_o,
    output logic [2:0][CNT_W-1:0]      err_cnt_o
);

    if_id_bundle_t          bundles [3];
    if_id_bundle_t          voted;
    lane_health_e           lane_state [3];
    logic [2:0]             healthy, faulty, fault_req, last_healthy;
    logic [2:0]             mismatch, mism_evt;
    logic [1:0]             n_healthy, lo_idx, hi_idx;
    logic                   uncorrectable, evt;
    logic [IFID_BUNDLE_W-1:0] b0, b1, b2;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        assign bundles[i].valid        = lanes.instr_valid_id_i[i];
        assign bundles[i].rdata        = lanes.instr_rdata_id_i[i];
        assign bundles[i].pc           = lanes.pc_id_i[i];
        assign bundles[i].compressed   = lanes.is_compressed_id_i[i];
        assign bundles[i].illegal      = lanes.illegal_c_insn_id_i[i];
        assign bundles[i].fetch_failed = lanes.is_fetch_failed_i[i];

        cv32e40p_lane_health_fsm #(
            .PERM_THRESHOLD  (PERM_THRESHOLD),
            .CLEAR_THRESHOLD (CLEAR_THRESHOLD)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .evt          (evt),
            .mismatch     (mismatch[i]),
            .clear        (health_clear_i),
            .last_healthy (last_healthy[i]),
            .state        (lane_state[i]),
            .faulty       (faulty[i]),
            .fault_req    (fault_req[i])
        );
    end

    assign healthy   = ~faulty;
    assign n_healthy = {1'b0, healthy[0]} + {1'b0, healthy[1]} + {1'b0, healthy[2]};
    assign b0 = bundles[0];
    assign b1 = bundles[1];
    assign b2 = bundles[2];

    // Lowest and highest healthy lane indices
    always_comb begin
        lo_idx = 2'd0;
        hi_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (healthy[i]) lo_idx = 2'(i);
        end
        for (int i = 0; i < 3; i++) begin
            if (healthy[i]) hi_idx = 2'(i);
        end
    end

    // A lane is kept alive when every other lane is retired or about to be
    // retired at a higher index, so at least the lowest survivor remains
    always_comb begin
        last_healthy = '1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j != i && !(faulty[j] || (j > i && fault_req[j]))) begin
                    last_healthy[i] = 1'b0;
                end
            end
        end
    end

    // Vote across the healthy lanes and flag mismatching lanes
    always_comb begin
        voted         = bundles[0];
        uncorrectable = 1'b0;
        mismatch      = '0;
        case (n_healthy)
            2'd3: begin
                voted         = (b0 & b1) | (b1 & b2) | (b0 & b2);
                uncorrectable = (b0 != b1) && (b1 != b2) && (b0 != b2);
                for (int i = 0; i < 3; i++) begin
                    mismatch[i] = (bundles[i] != voted);
                end
            end
            2'd2: begin
                voted            = bundles[lo_idx];
                uncorrectable    = (bundles[lo_idx] != bundles[hi_idx]);
                mismatch[lo_idx] = uncorrectable;
                mismatch[hi_idx] = uncorrectable;
            end
            2'd1: voted = bundles[lo_idx];
            default: ;
        endcase
    end

    assign evt      = voted.valid;
    assign mism_evt = mismatch & {3{evt}};

    assign instr_valid_o     = voted.valid;
    assign instr_rdata_o     = voted.rdata;
    assign is_compressed_o   = voted.compressed;
    assign illegal_c_insn_o  = voted.illegal;
    assign pc_o              = voted.pc;
    assign is_fetch_failed_o = voted.fetch_failed;
    assign kill_o            = uncorrectable & voted.valid;

    assign lane_faulty_o = faulty;
    assign degraded_o    = ((lane_state[0] == LANE_FAULTY) && (lane_state[1] == LANE_FAULTY))
                         || ((lane_state[1] == LANE_FAULTY) && (lane_state[2] == LANE_FAULTY))
                         || ((lane_state[0] == LANE_FAULTY) && (lane_state[2] == LANE_FAULTY));

    // Per-lane mismatch flags of event cycles, one cycle late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_mismatch_o <= '0;
        end else begin
            lane_mismatch_o <= mism_evt;
        end
    end

    // Refetch request: raised on a kill when idle, held until acknowledged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refetch_req_o <= 1'b0;
            refetch_pc_o  <= '0;
        end else if (!refetch_req_o && kill_o) begin
            refetch_req_o <= 1'b1;
            refetch_pc_o  <= bundles[lo_idx].pc;
        end else if (refetch_req_o && refetch_ack_i) begin
            refetch_req_o <= 1'b0;
        end
    end

`ifdef CV32E40P_IFID_ERR_CNT_EN
    logic [2:0][CNT_W-1:0] err_cnt_q;

    // Saturating per-lane mismatch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (health_clear_i) begin
                    err_cnt_q[i] <= '0;
                end else if (mism_evt[i] && (err_cnt_q[i] != '1)) begin
                    err_cnt_q[i] <= err_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_if_id_voter_ft.sv
// ============================================================================
// Module  : tb_cv32e40p_if_id_voter_ft
// Brief   : Self-checking bench for the IF/ID voter: directed vector table,
//           hand-written health/refetch sequences and randomized traffic
//           against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_if_id_voter_ft;
    import cv32e40p_pkg::*;

    localparam int PERM  = 4;
    localparam int CLEAR = 16;
    localparam int CNT_W = 4;
    localparam int NV    = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic health_clear, refetch_ack;
    logic instr_valid_o, is_compressed_o, illegal_c_insn_o, is_fetch_failed_o, kill_o;
    logic [31:0] instr_rdata_o, pc_o, refetch_pc_o;
    logic [2:0] lane_mismatch_o, lane_faulty_o;
    logic degraded_o, refetch_req_o;
    logic [2:0][CNT_W-1:0] err_cnt_o;

    always #5 clk = ~clk;

    cv32e40p_if_id_voter_ft_if lanes ();

    cv32e40p_if_id_voter_ft #(
        .PERM_THRESHOLD (PERM),
        .CLEAR_THRESHOLD(CLEAR),
        .CNT_W          (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lanes            (lanes),
        .health_clear_i   (health_clear),
        .refetch_ack_i    (refetch_ack),
        .instr_valid_o    (instr_valid_o),
        .instr_rdata_o    (instr_rdata_o),
        .is_compressed_o  (is_compressed_o),
        .illegal_c_insn_o (illegal_c_insn_o),
        .pc_o             (pc_o),
        .is_fetch_failed_o(is_fetch_failed_o),
        .kill_o           (kill_o),
        .lane_mismatch_o  (lane_mismatch_o),
        .lane_faulty_o    (lane_faulty_o),
        .degraded_o       (degraded_o),
        .refetch_req_o    (refetch_req_o),
        .refetch_pc_o     (refetch_pc_o),
        .err_cnt_o        (err_cnt_o)
    );

    typedef struct packed {
        logic [2:0]       valid;
        logic [2:0][31:0] rdata;
        logic [2:0][31:0] pc;
        logic [31:0]      exp_rdata;
        logic [31:0]      exp_pc;
        logic             exp_valid;
        logic             exp_kill;
        logic [2:0]       exp_mism;
    } vec_t;

    vec_t          tv [NV];
    if_id_bundle_t in_b [3];
    int            n_tests, n_fail;

    // Behavioural model state: 0 OK, 1 SUSPECT, 2 FAULTY
    int          m_st [3];
    int          m_run [3];
    bit          m_mm [3];
    bit          m_req;
    logic [31:0] m_rpc;
    logic [2:0]  m_mism;
    int          m_err [3];
    logic [IFID_BUNDLE_W-1:0] e_vote;
    bit          e_uncorr;
    bit [2:0]    e_mis;
    int          e_lo;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            lanes.instr_valid_id_i[i]    = in_b[i].valid;
            lanes.instr_rdata_id_i[i]    = in_b[i].rdata;
            lanes.pc_id_i[i]             = in_b[i].pc;
            lanes.is_compressed_id_i[i]  = in_b[i].compressed;
            lanes.illegal_c_insn_id_i[i] = in_b[i].illegal;
            lanes.is_fetch_failed_i[i]   = in_b[i].fetch_failed;
        end
    endtask

    task automatic set_all(input logic v, input logic [31:0] rd, input logic [31:0] pc);
        for (int i = 0; i < 3; i++) begin
            in_b[i]       = '0;
            in_b[i].valid = v;
            in_b[i].rdata = rd;
            in_b[i].pc    = pc;
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_run[i] = 0; m_mm[i] = 0; m_err[i] = 0;
        end
        m_req = 0; m_rpc = '0; m_mism = '0;
    endtask

    // Expected voted bundle from the lanes that are not retired
    task automatic model_comb();
        int q[$];
        logic [IFID_BUNDLE_W-1:0] bb [3];
        int ones, eq_pairs;
        for (int i = 0; i < 3; i++) begin
            bb[i] = in_b[i];
            if (m_st[i] != 2) q.push_back(i);
        end
        e_mis = '0; e_uncorr = 0; e_lo = q[0];
        if (q.size() == 3) begin
            for (int k = 0; k < IFID_BUNDLE_W; k++) begin
                ones = 0;
                for (int i = 0; i < 3; i++) if (bb[i][k]) ones++;
                e_vote[k] = (ones >= 2);
            end
            eq_pairs = 0;
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 3; j++)
                    if (bb[i] == bb[j]) eq_pairs++;
            e_uncorr = (eq_pairs == 0);
            for (int i = 0; i < 3; i++) e_mis[i] = (bb[i] != e_vote);
        end else if (q.size() == 2) begin
            e_vote   = bb[q[0]];
            e_uncorr = (bb[q[0]] != bb[q[1]]);
            e_mis[q[0]] = e_uncorr;
            e_mis[q[1]] = e_uncorr;
        end else begin
            e_vote = bb[q[0]];
        end
    endtask

    task automatic model_commit(input bit clr, input bit ack);
        bit evt, kill;
        bit want [3];
        int alive;
        evt  = e_vote[67];
        kill = e_uncorr && evt;
        m_mism = evt ? e_mis : 3'b000;
`ifdef CV32E40P_IFID_ERR_CNT_EN
        for (int i = 0; i < 3; i++) begin
            if (clr) m_err[i] = 0;
            else if (evt && e_mis[i] && m_err[i] < (1 << CNT_W) - 1) m_err[i]++;
        end
`endif
        if (!m_req && kill) begin
            m_req = 1; m_rpc = in_b[e_lo].pc;
        end else if (m_req && ack) begin
            m_req = 0;
        end
        if (clr) begin
            for (int i = 0; i < 3; i++) begin m_st[i] = 0; m_run[i] = 0; m_mm[i] = 0; end
        end else if (evt) begin
            for (int i = 0; i < 3; i++) begin
                want[i] = 0;
                if (m_st[i] == 0 && e_mis[i]) begin
                    m_st[i] = 1; m_run[i] = 1; m_mm[i] = 1;
                end else if (m_st[i] == 1) begin
                    if (e_mis[i]) begin
                        m_run[i] = m_mm[i] ? m_run[i] + 1 : 1;
                        m_mm[i]  = 1;
                        want[i]  = (m_run[i] >= PERM);
                    end else begin
                        m_run[i] = m_mm[i] ? 1 : m_run[i] + 1;
                        m_mm[i]  = 0;
                        if (m_run[i] >= CLEAR) begin m_st[i] = 0; m_run[i] = 0; end
                    end
                end
            end
            alive = 0;
            for (int i = 0; i < 3; i++) if (m_st[i] != 2 && !want[i]) alive++;
            if (alive == 0) begin
                for (int i = 2; i >= 0; i--) if (m_st[i] != 2) e_lo = i;
                want[e_lo] = 0;
            end
            for (int i = 0; i < 3; i++) if (want[i]) m_st[i] = 2;
        end
    endtask

    task automatic check_regs();
        logic [2:0] f;
        int nf;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            f[i] = (m_st[i] == 2);
            if (f[i]) nf++;
        end
        chk("lane_mismatch", lane_mismatch_o, m_mism);
        chk("lane_faulty", lane_faulty_o, f);
        chk("degraded", degraded_o, nf >= 2);
        chk("refetch_req", refetch_req_o, m_req);
        chk("refetch_pc", refetch_pc_o, m_rpc);
        for (int i = 0; i < 3; i++) chk("err_cnt", err_cnt_o[i], m_err[i]);
    endtask

    // One model-checked cycle; starts and ends 1 time unit after a posedge
    task automatic step(input bit clr, input bit ack);
        drive();
        health_clear = clr;
        refetch_ack  = ack;
        #3;
        model_comb();
        chk("vote", {instr_valid_o, instr_rdata_o, pc_o, is_compressed_o,
                     illegal_c_insn_o, is_fetch_failed_o}, e_vote);
        chk("kill", kill_o, e_uncorr && e_vote[67]);
        @(posedge clk);
        model_commit(clr, ack);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        set_all(1'b0, 32'h0, 32'h0);
        drive();
        health_clear = 0; refetch_ack = 0;
        rst_n = 0;
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IFID_BUNDLE_W-1:0] base, t;
        int bad;
        n_tests = 0; n_fail = 0;

        tv[0] = '{3'b111, {32'h13, 32'h13, 32'h13}, {32'h100, 32'h100, 32'h100}, 32'h13, 32'h100, 1'b1, 1'b0, 3'b000};
        tv[1] = '{3'b111, {32'h13, 32'h33, 32'h13}, {32'h100, 32'h100, 32'h100}, 32'h13, 32'h100, 1'b1, 1'b0, 3'b010};
        tv[2] = '{3'b111, {32'h13, 32'h13, 32'h13}, {32'h100, 32'h100, 32'h104}, 32'h13, 32'h100, 1'b1, 1'b0, 3'b001};
        tv[3] = '{3'b011, {32'h13, 32'h13, 32'h13}, {32'h100, 32'h100, 32'h100}, 32'h13, 32'h100, 1'b1, 1'b0, 3'b100};
        tv[4] = '{3'b001, {32'h13, 32'h13, 32'h13}, {32'h100, 32'h100, 32'h100}, 32'h13, 32'h100, 1'b0, 1'b0, 3'b000};
        tv[5] = '{3'b000, {32'h4, 32'h2, 32'h1}, {32'h100, 32'h100, 32'h100}, 32'h0, 32'h100, 1'b0, 1'b0, 3'b000};
        tv[6] = '{3'b111, {32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF}, {32'h40, 32'h40, 32'h40}, 32'hDEADBEEF, 32'h40, 1'b1, 1'b0, 3'b010};
        tv[7] = '{3'b000, {32'h13, 32'h13, 32'h13}, {32'h200, 32'h104, 32'h100}, 32'h13, 32'h100, 1'b0, 1'b0, 3'b000};

        do_reset();

        // Reset values
        chk("rst_mismatch", lane_mismatch_o, 3'b000);
        chk("rst_faulty", lane_faulty_o, 3'b000);
        chk("rst_degraded", degraded_o, 1'b0);
        chk("rst_req", refetch_req_o, 1'b0);
        chk("rst_pc", refetch_pc_o, 32'h0);
        chk("rst_err", err_cnt_o, '0);

        // Directed vote table; health_clear held so every vector sees 3 OK lanes
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 3; i++) begin
                in_b[i]       = '0;
                in_b[i].valid = tv[v].valid[i];
                in_b[i].rdata = tv[v].rdata[i];
                in_b[i].pc    = tv[v].pc[i];
            end
            drive();
            health_clear = 1;
            #3;
            chk("tv_rdata", instr_rdata_o, tv[v].exp_rdata);
            chk("tv_pc", pc_o, tv[v].exp_pc);
            chk("tv_valid", instr_valid_o, tv[v].exp_valid);
            chk("tv_kill", kill_o, tv[v].exp_kill);
            @(posedge clk);
            #1;
            chk("tv_mism", lane_mismatch_o, tv[v].exp_mism);
        end

        do_reset();

        // Single-bit upset on lane 1
        set_all(1'b1, 32'h13, 32'h100);
        in_b[1].rdata = 32'h33;
        step(0, 0);
        chk("seu_mism", lane_mismatch_o, 3'b010);
        set_all(1'b1, 32'h13, 32'h100);
        step(0, 0);

        // Lane 2 persistently wrong -> FAULTY after the 4th event
        in_b[2].rdata = 32'h93;
        repeat (4) step(0, 0);
        chk("perm_faulty", lane_faulty_o, 3'b100);
        chk("perm_rdata", instr_rdata_o, 32'h13);

        // Two healthy lanes disagree on pc -> kill and refetch
        set_all(1'b1, 32'h13, 32'h100);
        in_b[1].pc = 32'h104;
        drive();
        #1;
        chk("kill_2lane", kill_o, 1'b1);
        step(0, 0);
        chk("rf_req1", refetch_req_o, 1'b1);
        chk("rf_pc1", refetch_pc_o, 32'h100);
        set_all(1'b1, 32'h13, 32'h100);
        step(0, 0);
        chk("rf_req2", refetch_req_o, 1'b1);
        set_all(1'b1, 32'h13, 32'h200);
        in_b[1].pc = 32'h204;
        step(0, 0);
        chk("rf_req3", refetch_req_o, 1'b1);
        chk("rf_pc3", refetch_pc_o, 32'h100);
        set_all(1'b1, 32'h13, 32'h100);
        step(0, 1);
        chk("rf_drop", refetch_req_o, 1'b0);

        // Lanes 0/1 keep disagreeing: lane 1 retired, lane 0 kept
        set_all(1'b1, 32'h13, 32'h100);
        in_b[1].rdata = 32'h17;
        repeat (4) step(0, 1);
        chk("last_faulty", lane_faulty_o, 3'b110);
        chk("last_degraded", degraded_o, 1'b1);
        repeat (5) step(0, 1);
        chk("last_hold", lane_faulty_o, 3'b110);
        step(1, 1);
        chk("clr_faulty", lane_faulty_o, 3'b000);
        chk("clr_degraded", degraded_o, 1'b0);

        // Mismatches on invalid cycles are ignored
        set_all(1'b0, 32'h13, 32'h100);
        in_b[2].rdata = 32'hFF;
        repeat (6) step(0, 1);
        chk("inv_faulty", lane_faulty_o, 3'b000);
        chk("inv_mism", lane_mismatch_o, 3'b000);

        // Lane 0 mismatches in runs of 3 so it never retires; counter saturates
        for (int k = 0; k < 27; k++) begin
            set_all(1'b1, 32'h13, 32'h100);
            if (k % 4 != 3) in_b[0].rdata = 32'h11;
            step(0, 1);
        end
`ifdef CV32E40P_IFID_ERR_CNT_EN
        chk("err_sat", err_cnt_o[0], 4'hF);
`else
        chk("err_tied", err_cnt_o[0], 4'h0);
`endif

        // Randomized traffic against the model
        bad = 3;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) bad = $urandom_range(0, 3);
            base = {$urandom, $urandom, $urandom};
            base[67] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                t = base;
                if ($urandom_range(0, (i == bad) ? 1 : 9) == 0) t[$urandom_range(0, 67)] ^= 1'b1;
                in_b[i] = t;
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
